rtc_bcd_param: RTL and testbench
================================

Name: rtc_bcd_param

Overview:
Parametrised successor to the fixed 100 MHz six-digit BCD real-time clock. It derives a 1 Hz tick from a configurable input clock frequency and keeps hh:mm:ss as six BCD digits, in either 24-hour or 12-hour (AM/PM) mode. It adds run/stop control, a validated synchronous time-load port and a one-cycle seconds-tick strobe. It sits between the board clock and the display/driver logic.

Parameters:
CLK_FREQ_HZ, 100000000, input clock frequency; prescaler terminal count = CLK_FREQ_HZ-1; must be >= 2.
MODE_12H, 0, 0 = 24-hour mode (00..23); 1 = 12-hour mode (12,01..11 with PM flag).
PRESC_W, $clog2(CLK_FREQ_HZ), prescaler counter width.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
run  input  1  1 = prescaler counts and time advances; 0 = freeze (prescaler holds)
load  input  1  one-cycle request to load the load_* fields
load_hours  input  8  BCD {tens,units}
load_minutes  input  8  BCD {tens,units}
load_seconds  input  8  BCD {tens,units}
load_pm  input  1  PM flag for the load (ignored when MODE_12H=0)
left_seconds_out  output  4  seconds tens digit
right_seconds_out  output  4  seconds units digit
left_minutes_out  output  4  minutes tens digit
right_minutes_out  output  4  minutes units digit
left_hours_out  output  4  hours tens digit
right_hours_out  output  4  hours units digit
pm_out  output  1  PM indicator (held 0 when MODE_12H=0)
sec_tick  output  1  one-cycle pulse coincident with each seconds increment
load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (asynchronous, active-high): prescaler=0; sec_tick=0; load_err=0; pm_out=0. Time resets to 00:00:00 when MODE_12H=0 and to 12:00:00 AM when MODE_12H=1. All outputs are registered.
- Prescaler: while run=1, it increments every clk. On reaching CLK_FREQ_HZ-1 it wraps to 0 and raises an internal tick for that cycle.
- Tick latency: the digits and sec_tick update on the clk edge after the cycle in which the prescaler equals CLK_FREQ_HZ-1. Period is exactly CLK_FREQ_HZ cycles.
- Cascade (ripple in the same cycle, no extra latency):
  - seconds units 9->0 carries into seconds tens;
  - seconds tens 5->0 carries into minutes;
  - minutes units and tens follow the same pattern;
  - the minutes 59->00 carry advances hours.
- 24-hour rollover: hours 23->00. 23:59:59 -> 00:00:00 in a single tick.
- 12-hour rollover: hours 12->01, then 09->10, 11->12. pm_out toggles on the 11:59:59 -> 12:00:00 transition. Hours never show 00.
- run=0: prescaler and time hold; sec_tick=0. On return to run=1, counting resumes from the held prescaler value.
- Load validity rules:
  - every digit <= 9;
  - seconds and minutes tens digit <= 5;
  - hours 00..23 in 24-hour mode; 01..12 in 12-hour mode.
- Valid load: on the next edge, time = load fields and pm_out = load_pm (12-hour mode only); prescaler cleared to 0; sec_tick=0.
- Invalid load: time, pm_out and prescaler are unchanged, and load_err pulses for 1 cycle.
- load and tick in the same cycle: load wins and the tick is discarded; a rejected load does not discard the tick.
- load while run=0 is accepted; time stays frozen at the loaded value.
- Reset asserted mid-count or mid-load: immediate return to the reset state; pending load is lost.

Decomposition:
- Shared package rtc_pkg:
  - BCD digit typedef (4 bits);
  - limits MAX_SEC_TENS=5, MAX_HR24=23, MAX_HR12=12, MIN_HR12=1;
  - reset time constants per mode;
  - the BCD validity-check function.
- Sub-module bcd_digit_counter, instanced for seconds and minutes:
  - ports clk, reset, inc, load, load_val, MAX parameter;
  - outputs count and carry;
  - carry = inc and (count==MAX).
- The hours counter stays inline because of the mode-specific wrap.

Test Plan (benches use CLK_FREQ_HZ=10):
1. Release reset at 100 ns with run=1 -> 00:00:00 held; first sec_tick and display 00:00:01 exactly 10 clk after reset release; sec_tick period 10 clk.
2. Load 23:59:58 (24-hour) -> two ticks later 00:00:00; prescaler restart verified by the first tick arriving exactly 10 clk after the load.
3. MODE_12H=1, load 11:59:59 with load_pm=0 -> next tick 12:00:00 with pm_out=1; load 12:59:59 -> next tick 01:00:00 with pm_out unchanged.
4. Invalid loads 24:00:00 (24-hour), 00:30:00 (12-hour), 12:60:00 and 12:0A:00 -> load_err one-cycle pulse each; time unchanged.
5. run=0 for 35 clk mid-second -> digits and prescaler frozen, no sec_tick; after run=1 the tick arrives after the remaining prescaler count.
6. load asserted in the same cycle as the prescaler terminal count -> loaded value shown, no increment, sec_tick=0; reset asserted mid-second -> immediate reset time and no sec_tick.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types, limits and load-validation helper for the parametrised BCD
// real-time clock.
package rtc_pkg;

    typedef logic [3:0] bcd_t;

    localparam int MAX_SEC_TENS = 5;
    localparam int MAX_HR24     = 23;
    localparam int MAX_HR12     = 12;
    localparam int MIN_HR12     = 1;

    localparam logic [7:0] RESET_HOURS_24H = 8'h00;
    localparam logic [7:0] RESET_HOURS_12H = 8'h12;

    // Accepts a {tens,units} BCD time only if it is displayable in the given mode.
    function automatic logic bcd_time_valid(
        input logic [7:0] hours,
        input logic [7:0] minutes,
        input logic [7:0] seconds,
        input logic       mode_12h
    );
        logic       ok;
        logic [7:0] hr_bin;
        ok = (hours[7:4]   <= 4'd9) && (hours[3:0]   <= 4'd9) &&
             (minutes[3:0] <= 4'd9) && (seconds[3:0] <= 4'd9) &&
             (minutes[7:4] <= 4'(MAX_SEC_TENS)) &&
             (seconds[7:4] <= 4'(MAX_SEC_TENS));
        hr_bin = 8'(hours[7:4]) * 8'd10 + 8'(hours[3:0]);
        if (mode_12h) begin
            ok = ok && (hr_bin >= 8'(MIN_HR12)) && (hr_bin <= 8'(MAX_HR12));
        end else begin
            ok = ok && (hr_bin <= 8'(MAX_HR24));
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit that counts 0..MAX on inc, with synchronous load and a
// combinational carry used to ripple into the next digit.
module bcd_digit_counter
    import rtc_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t count,
    output logic carry
);

    bcd_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d = (count_q == MAX) ? 4'd0 : count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign carry = inc && (count_q == MAX);

endmodule

// File: rtl/rtc_bcd_param.sv
// Six-digit BCD hh:mm:ss clock with a parametrised 1 Hz prescaler, 12/24-hour
// mode, run/stop control and a validated synchronous time load.
module rtc_bcd_param
    import rtc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int MODE_12H    = 0,
    parameter int PRESC_W     = $clog2(CLK_FREQ_HZ)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] load_hours,
    input  logic [7:0] load_minutes,
    input  logic [7:0] load_seconds,
    input  logic       load_pm,
    output logic [3:0] left_seconds_out,
    output logic [3:0] right_seconds_out,
    output logic [3:0] left_minutes_out,
    output logic [3:0] right_minutes_out,
    output logic [3:0] left_hours_out,
    output logic [3:0] right_hours_out,
    output logic       pm_out,
    output logic       sec_tick,
    output logic       load_err
);

    localparam logic                 MODE12      = (MODE_12H != 0);
    localparam logic [PRESC_W-1:0]   PRESC_TERM  = PRESC_W'(CLK_FREQ_HZ - 1);
    localparam logic [7:0]           RESET_HOURS = MODE12 ? RESET_HOURS_12H : RESET_HOURS_24H;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               sec_tick_q, sec_tick_d;
    logic               load_err_q, load_err_d;
    logic               pm_q, pm_d;
    bcd_t               hr_tens_q, hr_tens_d;
    bcd_t               hr_units_q, hr_units_d;

    logic               load_valid, load_ok, tick, sec_inc;
    bcd_t               sec_units, sec_tens, min_units, min_tens;
    logic               sec_units_carry, sec_tens_carry, min_units_carry, min_tens_carry;
    logic [4:0]         hr_bin, hr_next;
    bcd_t               hr_next_tens;

    // An accepted load restarts the second and swallows a coinciding tick;
    // a rejected load leaves the tick alone.
    always_comb begin
        load_valid = bcd_time_valid(load_hours, load_minutes, load_seconds, MODE12);
        load_ok    = load && load_valid;
        tick       = run && (presc_q == PRESC_TERM);
        sec_inc    = tick && !load_ok;
        sec_tick_d = sec_inc;
        load_err_d = load && !load_valid;

        presc_d = presc_q;
        if (load_ok) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    bcd_digit_counter #(.MAX(4'd9)) u_sec_units (
        .clk(clk), .reset(reset), .inc(sec_inc), .load(load_ok),
        .load_val(load_seconds[3:0]), .count(sec_units), .carry(sec_units_carry)
    );

    bcd_digit_counter #(.MAX(4'(MAX_SEC_TENS))) u_sec_tens (
        .clk(clk), .reset(reset), .inc(sec_units_carry), .load(load_ok),
        .load_val(load_seconds[7:4]), .count(sec_tens), .carry(sec_tens_carry)
    );

    bcd_digit_counter #(.MAX(4'd9)) u_min_units (
        .clk(clk), .reset(reset), .inc(sec_tens_carry), .load(load_ok),
        .load_val(load_minutes[3:0]), .count(min_units), .carry(min_units_carry)
    );

    bcd_digit_counter #(.MAX(4'(MAX_SEC_TENS))) u_min_tens (
        .clk(clk), .reset(reset), .inc(min_units_carry), .load(load_ok),
        .load_val(load_minutes[7:4]), .count(min_tens), .carry(min_tens_carry)
    );

    // Hours are incremented in binary and split back into BCD, which keeps the
    // 23->00 and 12->01 wraps readable. PM flips on the 11->12 step.
    always_comb begin
        hr_bin  = 5'(hr_tens_q) * 5'd10 + 5'(hr_units_q);
        hr_next = hr_bin + 5'd1;
        if (MODE12) begin
            if (hr_bin == 5'(MAX_HR12)) begin
                hr_next = 5'(MIN_HR12);
            end
        end else if (hr_bin == 5'(MAX_HR24)) begin
            hr_next = 5'd0;
        end
        hr_next_tens = (hr_next >= 5'd20) ? 4'd2 : (hr_next >= 5'd10) ? 4'd1 : 4'd0;

        hr_tens_d  = hr_tens_q;
        hr_units_d = hr_units_q;
        pm_d       = pm_q;
        if (load_ok) begin
            hr_tens_d  = load_hours[7:4];
            hr_units_d = load_hours[3:0];
            pm_d       = MODE12 ? load_pm : 1'b0;
        end else if (min_tens_carry) begin
            hr_tens_d  = hr_next_tens;
            hr_units_d = 4'(hr_next - 5'(hr_next_tens) * 5'd10);
            if (MODE12 && (hr_bin == 5'(MAX_HR12 - 1))) begin
                pm_d = ~pm_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
            pm_q       <= 1'b0;
            hr_tens_q  <= RESET_HOURS[7:4];
            hr_units_q <= RESET_HOURS[3:0];
        end else begin
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
            load_err_q <= load_err_d;
            pm_q       <= pm_d;
            hr_tens_q  <= hr_tens_d;
            hr_units_q <= hr_units_d;
        end
    end

    assign left_seconds_out  = sec_tens;
    assign right_seconds_out = sec_units;
    assign left_minutes_out  = min_tens;
    assign right_minutes_out = min_units;
    assign left_hours_out    = hr_tens_q;
    assign right_hours_out   = hr_units_q;
    assign pm_out            = pm_q;
    assign sec_tick          = sec_tick_q;
    assign load_err          = load_err_q;

endmodule

// File: tb/tb_rtc_bcd_param.sv
// Bench for rtc_bcd_param: a 24-hour and a 12-hour instance share stimulus and
// are compared every cycle against a seconds-of-day reference model.
module tb_rtc_bcd_param;

   localparam int F = 10;

   logic       clk = 1'b0;
   logic       reset, run, load, load_pm;
   logic [7:0] load_hours, load_minutes, load_seconds;

   logic [3:0] d_ls [2];
   logic [3:0] d_rs [2];
   logic [3:0] d_lm [2];
   logic [3:0] d_rm [2];
   logic [3:0] d_lh [2];
   logic [3:0] d_rh [2];
   logic       d_pm [2];
   logic       d_tick [2];
   logic       d_err [2];

   int  m_sod [2];
   int  m_presc [2];
   bit  m_tick [2];
   bit  m_err [2];

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
      logic       pm;
      logic       err24;
      logic       err12;
   } loadVec_t;

   loadVec_t tbl [10];

   always #5 clk = ~clk;

   rtc_bcd_param #(.CLK_FREQ_HZ(F), .MODE_12H(0)) dut24 (
      .clk(clk), .reset(reset), .run(run), .load(load),
      .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
      .load_pm(load_pm),
      .left_seconds_out(d_ls[0]), .right_seconds_out(d_rs[0]),
      .left_minutes_out(d_lm[0]), .right_minutes_out(d_rm[0]),
      .left_hours_out(d_lh[0]), .right_hours_out(d_rh[0]),
      .pm_out(d_pm[0]), .sec_tick(d_tick[0]), .load_err(d_err[0])
   );

   rtc_bcd_param #(.CLK_FREQ_HZ(F), .MODE_12H(1)) dut12 (
      .clk(clk), .reset(reset), .run(run), .load(load),
      .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
      .load_pm(load_pm),
      .left_seconds_out(d_ls[1]), .right_seconds_out(d_rs[1]),
      .left_minutes_out(d_lm[1]), .right_minutes_out(d_rm[1]),
      .left_hours_out(d_lh[1]), .right_hours_out(d_rh[1]),
      .pm_out(d_pm[1]), .sec_tick(d_tick[1]), .load_err(d_err[1])
   );

   // Reference model: time is an integer second of the day; 12-hour mode is
   // purely a different way of displaying the same count.
   function automatic bit modelValid(input logic [7:0] hh, input logic [7:0] mm,
                                     input logic [7:0] ss, input int m);
      int h;
      if (int'(hh[7:4]) > 9 || int'(hh[3:0]) > 9 || int'(mm[7:4]) > 5 ||
          int'(mm[3:0]) > 9 || int'(ss[7:4]) > 5 || int'(ss[3:0]) > 9) return 1'b0;
      h = int'(hh[7:4]) * 10 + int'(hh[3:0]);
      if (m == 1) return (h >= 1 && h <= 12);
      return (h <= 23);
   endfunction

   function automatic int modelLoadSod(input logic [7:0] hh, input logic [7:0] mm,
                                       input logic [7:0] ss, input logic pm, input int m);
      int h;
      h = int'(hh[7:4]) * 10 + int'(hh[3:0]);
      if (m == 1) h = (h % 12) + (pm ? 12 : 0);
      return h * 3600 + (int'(mm[7:4]) * 10 + int'(mm[3:0])) * 60 +
             int'(ss[7:4]) * 10 + int'(ss[3:0]);
   endfunction

   function automatic logic [26:0] expVec(input int m);
      int h, mi, s;
      logic pm;
      h  = m_sod[m] / 3600;
      mi = (m_sod[m] / 60) % 60;
      s  = m_sod[m] % 60;
      pm = 1'b0;
      if (m == 1) begin
         pm = (h >= 12);
         h  = h % 12;
         if (h == 0) h = 12;
      end
      return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
              pm, m_tick[m], m_err[m]};
   endfunction

   function automatic logic [26:0] actVec(input int m);
      return {d_lh[m], d_rh[m], d_lm[m], d_rm[m], d_ls[m], d_rs[m], d_pm[m], d_tick[m], d_err[m]};
   endfunction

   task automatic modelReset();
      for (int m = 0; m < 2; m++) begin
         m_sod[m] = 0; m_presc[m] = 0; m_tick[m] = 1'b0; m_err[m] = 1'b0;
      end
   endtask

   task automatic modelStep();
      bit t;
      if (reset) begin
         modelReset();
         return;
      end
      for (int m = 0; m < 2; m++) begin
         t = run && (m_presc[m] == F - 1);
         if (load && modelValid(load_hours, load_minutes, load_seconds, m)) begin
            m_sod[m]   = modelLoadSod(load_hours, load_minutes, load_seconds, load_pm, m);
            m_presc[m] = 0;
            m_tick[m]  = 1'b0;
            m_err[m]   = 1'b0;
         end else begin
            m_err[m] = load;
            if (run) m_presc[m] = (m_presc[m] + 1) % F;
            if (t) m_sod[m] = (m_sod[m] + 1) % 86400;
            m_tick[m] = t;
         end
      end
   endtask

   task automatic checkOutput();
      for (int m = 0; m < 2; m++) begin
         vectors++;
         if (actVec(m) !== expVec(m)) begin
            miscompares++;
            $display("[TB] FAIL cycle_check_%s t=%0t got hh:mm:ss/pm/tick/err=%h required=%h",
                     (m == 0) ? "dut24" : "dut12", $time, actVec(m), expVec(m));
         end
      end
   endtask

   task automatic checkValue(input string name, input int got, input int req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("[TB] FAIL %s t=%0t got=%0h required=%0h", name, $time, got, req);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic l, input logic [7:0] hh,
                                input logic [7:0] mm, input logic [7:0] ss, input logic pm);
      run = r; load = l; load_hours = hh; load_minutes = mm; load_seconds = ss; load_pm = pm;
   endtask

   task automatic clockCycle();
      modelStep();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic waitTick(input int m, output int n);
      n = 0;
      do begin
         clockCycle();
         n++;
      end while (d_tick[m] !== 1'b1 && n < 50);
   endtask

   task automatic doReset();
      reset = 1'b1;
      modelReset();
      #1;
      checkOutput();
      checkValue("async_reset_tick", int'(d_tick[0]), 0);
      clockCycle();
      reset = 1'b0;
   endtask

   initial begin
      int n, ticks, sel, h, mi, s;
      logic [7:0] hh, mm, ss;

      tbl[0] = '{8'h24, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[1] = '{8'h00, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{8'h12, 8'h60, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[3] = '{8'h12, 8'h0A, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{8'h1A, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[5] = '{8'h05, 8'h00, 8'h60, 1'b1, 1'b1, 1'b1};
      tbl[6] = '{8'h13, 8'h45, 8'h07, 1'b1, 1'b0, 1'b1};
      tbl[7] = '{8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[8] = '{8'h09, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0};
      tbl[9] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};

      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      modelReset();
      repeat (10) @(negedge clk);
      checkOutput();
      checkValue("reset_hours24", int'({d_lh[0], d_rh[0]}), 'h00);
      checkValue("reset_hours12", int'({d_lh[1], d_rh[1]}), 'h12);
      reset = 1'b0;

      // First second after reset release and the steady tick period.
      waitTick(0, n);
      checkValue("first_tick_latency", n, 10);
      checkValue("first_tick_seconds", int'({d_ls[0], d_rs[0]}), 'h01);
      waitTick(0, n);
      checkValue("tick_period", n, 10);

      // 24-hour midnight rollover, prescaler restarted by the load.
      applyStimulus(1'b1, 1'b1, 8'h23, 8'h59, 8'h58, 1'b0);
      clockCycle();
      applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      waitTick(0, n);
      checkValue("load_to_tick", n, 10);
      waitTick(0, n);
      checkValue("rollover24_period", n, 10);
      checkValue("rollover24_time", int'({d_lh[0], d_rh[0], d_lm[0], d_rm[0], d_ls[0], d_rs[0]}), 0);

      // 12-hour: 11:59:59 AM -> 12 PM, then 12:59:59 PM -> 1 PM.
      applyStimulus(1'b1, 1'b1, 8'h11, 8'h59, 8'h59, 1'b0);
      clockCycle();
      applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      waitTick(1, n);
      checkValue("noon_period", n, 10);
      checkValue("noon_hours12", int'({d_lh[1], d_rh[1]}), 'h12);
      checkValue("noon_pm", int'(d_pm[1]), 1);
      checkValue("noon_hours24", int'({d_lh[0], d_rh[0]}), 'h12);
      applyStimulus(1'b1, 1'b1, 8'h12, 8'h59, 8'h59, 1'b1);
      clockCycle();
      applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      waitTick(1, n);
      checkValue("one_pm_hours12", int'({d_lh[1], d_rh[1]}), 'h01);
      checkValue("one_pm_pm", int'(d_pm[1]), 1);
      checkValue("one_pm_hours24", int'({d_lh[0], d_rh[0]}), 'h13);

      // Load validation table with the clock frozen.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b1, tbl[i].hh, tbl[i].mm, tbl[i].ss, tbl[i].pm);
         clockCycle();
         checkValue($sformatf("load_err24_%0d", i), int'(d_err[0]), int'(tbl[i].err24));
         checkValue($sformatf("load_err12_%0d", i), int'(d_err[1]), int'(tbl[i].err12));
         applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
         clockCycle();
         checkValue($sformatf("load_err_pulse_%0d", i), int'(d_err[0] | d_err[1]), 0);
      end

      // Freeze mid-second for 35 cycles, then resume from the held count.
      applyStimulus(1'b1, 1'b1, 8'h05, 8'h10, 8'h20, 1'b0);
      clockCycle();
      applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      repeat (4) clockCycle();
      run = 1'b0;
      ticks = 0;
      for (int i = 0; i < 35; i++) begin
         clockCycle();
         ticks += int'(d_tick[0]) + int'(d_tick[1]);
      end
      checkValue("frozen_ticks", ticks, 0);
      checkValue("frozen_seconds", int'({d_ls[0], d_rs[0]}), 'h20);
      run = 1'b1;
      waitTick(0, n);
      checkValue("resume_remaining", n, 6);

      // Load coinciding with the terminal count wins; then reset mid-second.
      applyStimulus(1'b1, 1'b1, 8'h01, 8'h02, 8'h03, 1'b0);
      clockCycle();
      applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      repeat (9) clockCycle();
      applyStimulus(1'b1, 1'b1, 8'h10, 8'h20, 8'h30, 1'b0);
      clockCycle();
      applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      checkValue("load_vs_tick_strobe", int'(d_tick[0]), 0);
      checkValue("load_vs_tick_time", int'({d_lh[0], d_rh[0], d_lm[0], d_rm[0], d_ls[0], d_rs[0]}), 'h102030);
      repeat (3) clockCycle();
      doReset();
      checkValue("reset_mid_second", int'({d_lh[1], d_rh[1], d_lm[1], d_rm[1], d_ls[1], d_rs[1]}), 'h120000);

      // Randomised traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 799) == 0) begin
            doReset();
         end else begin
            sel = int'($urandom_range(0, 3));
            h = int'($urandom_range(0, 23));
            mi = int'($urandom_range(0, 59));
            s = int'($urandom_range(0, 59));
            hh = {4'(h / 10), 4'(h % 10)};
            mm = {4'(mi / 10), 4'(mi % 10)};
            ss = {4'(s / 10), 4'(s % 10)};
            if (sel == 1) begin
               case ($urandom_range(0, 2))
                  0: hh = 8'h23;
                  1: hh = 8'h11;
                  default: hh = 8'h12;
               endcase
               mm = 8'h59;
               ss = {4'd5, 4'($urandom_range(5, 9))};
            end else if (sel == 2) begin
               hh = 8'($urandom);
               mm = 8'($urandom);
               ss = 8'($urandom);
            end
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                          hh, mm, ss, 1'($urandom_range(0, 1)));
            clockCycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
